// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared multi-cycle ALU.
// Registered IDLE/ISSUE/WAIT/DONE controller with an ALU response timeout.
module alu_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 15
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    req0,
  input  logic                    req1,
  input  logic [DATA_WIDTH-1:0]   a0,
  input  logic [DATA_WIDTH-1:0]   b0,
  input  logic [DATA_WIDTH-1:0]   a1,
  input  logic [DATA_WIDTH-1:0]   b1,
  input  logic [3:0]              fun0,
  input  logic [3:0]              fun1,
  output logic                    gnt0,
  output logic                    gnt1,
  output logic                    done0,
  output logic                    done1,
  output logic [2*DATA_WIDTH-1:0] res,
  output logic                    timeout_err,
  output logic                    busy,
  output logic [DATA_WIDTH-1:0]   alu_a,
  output logic [DATA_WIDTH-1:0]   alu_b,
  output logic [3:0]              alu_fun,
  output logic                    alu_en,
  input  logic [2*DATA_WIDTH-1:0] alu_out,
  input  logic                    alu_valid
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  // The last WAIT cycle is the one in which the counter holds TIMEOUT-1.
  localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);

  state_t                  state_q;
  logic                    ptr_q;
  logic                    win_q;
  logic [3:0]              cnt_q;
  logic                    gnt0_q, gnt1_q, done0_q, done1_q;
  logic                    terr_q, busy_q, alu_en_q;
  logic [2*DATA_WIDTH-1:0] res_q;
  logic [DATA_WIDTH-1:0]   alu_a_q, alu_b_q;
  logic [3:0]              alu_fun_q;
  logic                    sel_d;

  // A lone requester wins outright; on contention the pointer decides.
  assign sel_d = (req0 && req1) ? ptr_q : req1;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      ptr_q     <= 1'b0;
      win_q     <= 1'b0;
      cnt_q     <= '0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      terr_q    <= 1'b0;
      busy_q    <= 1'b0;
      alu_en_q  <= 1'b0;
      res_q     <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_fun_q <= '0;
    end else begin
      // NOTE: pulse outputs default low each cycle and are raised only by the transition that owns them.
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      alu_en_q <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      terr_q   <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (req0 || req1) begin
            win_q     <= sel_d;
            alu_a_q   <= sel_d ? a1 : a0;
            alu_b_q   <= sel_d ? b1 : b0;
            alu_fun_q <= sel_d ? fun1 : fun0;
            gnt0_q    <= ~sel_d;
            gnt1_q    <= sel_d;
            alu_en_q  <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          cnt_q <= cnt_q + 4'd1;
          if (alu_valid || cnt_q == CNT_LAST) begin
            res_q   <= alu_valid ? alu_out : '0;
            terr_q  <= ~alu_valid;
            done0_q <= ~win_q;
            done1_q <= win_q;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          ptr_q   <= ~win_q;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign gnt0        = gnt0_q;
  assign gnt1        = gnt1_q;
  assign done0       = done0_q;
  assign done1       = done1_q;
  assign res         = res_q;
  assign timeout_err = terr_q;
  assign busy        = busy_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_fun     = alu_fun_q;
  assign alu_en      = alu_en_q;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the operand width; results are 2*DATA_WIDTH.
REQ-002 Parameter TIMEOUT, default 15, SHALL set the maximum number of WAIT cycles before an ALU timeout.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset:
  CLK  in  1  rising-edge clock
  RST  in  1  asynchronous, active-high reset
REQ-004 The requester-side ports SHALL be:
  req0/req1  in  1  request from requester 0/1; held until grant
  a0,b0/a1,b1  in  DATA_WIDTH  operands
  fun0/fun1  in  4  ALU function; [3:2] unit select (00 arith, 01 logic, 10 cmp, 11 shift), [1:0] op
  gnt0/gnt1  out  1  one-cycle accept pulse
  done0/done1  out  1  one-cycle result-valid pulse
  res  out  2*DATA_WIDTH  result of the last completed op
  timeout_err  out  1  one-cycle pulse, coincident with done, when the ALU failed to respond
  busy  out  1  high whenever state is not IDLE
REQ-005 The ALU-side ports SHALL be:
  alu_a, alu_b  out  DATA_WIDTH  registered operands
  alu_fun  out  4  registered function code
  alu_en  out  1  one-cycle ALU enable
  alu_out  in  2*DATA_WIDTH  ALU result
  alu_valid  in  1  ALU result valid

Function
REQ-006 The FSM SHALL have four states, IDLE, ISSUE, WAIT and DONE, with a registered state and registered outputs.
REQ-007 In IDLE with req0 or req1 high, the block SHALL select a winner, capture its a/b/fun into alu_a/alu_b/alu_fun, and enter ISSUE on the next edge; with no request it SHALL stay in IDLE.
REQ-008 Arbitration SHALL be round-robin with a 1-bit priority pointer: the pointer requester wins simultaneous requests; a lone requester always wins.
REQ-009 The pointer SHALL move to the other requester in DONE and only in DONE; the reset value SHALL be requester 0.
REQ-010 In ISSUE, gnt of the winner and alu_en SHALL each be high for exactly that one cycle, and the FSM SHALL then enter WAIT unconditionally.
REQ-011 In WAIT, a 4-bit cycle counter SHALL clear on entry and increment each cycle.
REQ-012 If alu_valid is high in WAIT, the block SHALL load alu_out into res and enter DONE.
REQ-013 If the counter reaches TIMEOUT with no alu_valid, the block SHALL load res with 0, set an internal timeout flag, and enter DONE.
REQ-014 If alu_valid and the timeout condition occur in the same cycle, the valid result SHALL win and no timeout SHALL be flagged.
REQ-015 In DONE, the winner's done SHALL pulse for one cycle, timeout_err SHALL pulse if flagged, and the FSM SHALL return to IDLE.
REQ-016 Minimum latency SHALL be: request sampled in IDLE at cycle 0, gnt/alu_en at cycle 1, alu_valid at cycle 2, done at cycle 3.
REQ-017 A new request SHALL be accepted no earlier than the IDLE cycle that follows DONE.
REQ-018 alu_valid SHALL be ignored in IDLE, ISSUE and DONE.
REQ-019 Requests arriving outside IDLE SHALL be held off and not lost, provided the requester keeps req high.
REQ-020 A req that drops before selection SHALL not be granted; a req that drops after selection SHALL not cancel the operation.
REQ-021 res, alu_a, alu_b and alu_fun SHALL hold their values until next overwritten.
REQ-022 gnt0 and gnt1 SHALL never be high together, and done0 and done1 SHALL never be high together.

Reset
REQ-023 While RST is high, state SHALL be IDLE, the pointer 0, the counter 0, and every output 0 (res, alu_a, alu_b, alu_fun, gnt*, done*, alu_en, busy, timeout_err).
REQ-024 Asserting RST mid-operation (ISSUE, WAIT or DONE) SHALL abort the operation with no done or timeout pulse after release.
REQ-025 After RST is released, the first rising edge SHALL evaluate requests from IDLE.

Verification
REQ-026 The bench SHALL cover single request: req0, a0=8'h05, b0=8'h03, fun0=4'b0000, ALU answers 1 cycle after alu_en -> gnt0 at cycle 1, alu_a=5, alu_b=3, alu_fun=0, done0 at cycle 3, res=16'h0008, busy high cycles 1-3.
REQ-027 The bench SHALL cover contention: req0 and req1 held high continuously from reset -> grants alternate 0,1,0,1 with no back-to-back grant to the same requester.
REQ-028 The bench SHALL cover timeout: req1 with alu_valid never asserted -> after 15 WAIT cycles, done1 and timeout_err pulse together, res=0, the next arbitration favours requester 0.
REQ-029 The bench SHALL cover the coincident case: alu_valid first high on the TIMEOUT count with alu_out=16'h00FF -> res=16'h00FF, timeout_err low.
REQ-030 The bench SHALL cover mid-operation reset: RST pulsed during WAIT -> all outputs 0 asynchronously, no done after release, the next req0 is granted normally.
REQ-031 The bench SHALL cover spurious valid: alu_valid pulsed in IDLE -> res unchanged, no done pulse.
